// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and widths for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_INST_W = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_wmask_gen.sv
// rtl/mem_wmask_gen.sv - byte-enable and misalignment decode from access size and low address bits
module mem_wmask_gen
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [2:0] addr_lo,
    output logic [7:0] wmask,
    output logic       misalign
);

    // Lane mask is the size's base pattern shifted to the byte offset inside the 64-bit word
    always_comb begin
        wmask    = 8'h00;
        misalign = 1'b0;
        case (size)
            SIZE_B: begin
                wmask    = 8'h01 << addr_lo;
                misalign = 1'b0;
            end
            SIZE_H: begin
                wmask    = 8'h03 << addr_lo;
                misalign = addr_lo[0];
            end
            SIZE_W: begin
                wmask    = 8'h0F << addr_lo;
                misalign = (addr_lo[1:0] != 2'b00);
            end
            default: begin
                wmask    = 8'hFF;
                misalign = (addr_lo != 3'b000);
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 64-bit memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int INST_W       = DEF_INST_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [INST_W-1:0] if_rsp_instr,
    output logic              if_rsp_err,

    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_wr,
    input  logic [1:0]        mem_req_size,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    output logic              mem_rsp_valid,
    output logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              mem_rsp_err,

    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_wr,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic [7:0]        bus_req_wmask,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic [CNT_W-1:0]  starve_cnt;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_wdata;
    logic [7:0]        lat_wmask;

    logic              grant_if, grant_mem, accept;
    logic [1:0]        sel_size;
    logic [2:0]        sel_addr_lo;
    logic [7:0]        sel_wmask;
    logic              sel_misalign;
    logic              rsp_done;

    // Fetch wins only when MEM is idle or IF has been starved for the full limit
    assign grant_if  = if_req_valid && (!mem_req_valid || (starve_cnt == CNT_MAX));
    assign grant_mem = mem_req_valid && !grant_if;
    assign accept    = if_req_ready || mem_req_ready;
    assign rsp_done  = (state == ST_WAIT) && bus_rsp_valid;

    // Fetches are decoded as word accesses so the shared mask/misalign logic covers them too
    assign sel_size    = grant_if ? SIZE_W : mem_req_size;
    assign sel_addr_lo = grant_if ? if_req_addr[2:0] : mem_req_addr[2:0];

    mem_wmask_gen u_wmask_gen (
        .size     (sel_size),
        .addr_lo  (sel_addr_lo),
        .wmask    (sel_wmask),
        .misalign (sel_misalign)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one transaction at a time, misaligned requests bypass the bus
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = sel_misalign ? ST_ERR : ST_REQ;
            ST_REQ:  if (bus_req_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (bus_rsp_valid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs: readies only in IDLE, bus request only in REQ
    always_comb begin
        if_req_ready  = 1'b0;
        mem_req_ready = 1'b0;
        bus_req_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if_req_ready  = grant_if;
                mem_req_ready = grant_mem;
            end
            ST_REQ:  bus_req_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus_req_wr    = lat_wr;
    assign bus_req_addr  = lat_addr;
    assign bus_req_wdata = lat_wdata;
    assign bus_req_wmask = lat_wmask;

    // Request latch and owner tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_NONE;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= 8'h00;
        end else if (accept) begin
            owner     <= grant_if ? OWN_IF : OWN_MEM;
            lat_addr  <= grant_if ? if_req_addr : mem_req_addr;
            lat_wr    <= grant_if ? 1'b0 : mem_req_wr;
            lat_wdata <= grant_if ? '0 : mem_req_wdata;
            lat_wmask <= sel_wmask;
        end else if (rsp_done || (state == ST_ERR)) begin
            owner     <= OWN_NONE;
        end
    end

    // Starvation counter: counts MEM grants taken while IF waits, saturating at the limit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (!if_req_valid || grant_if)
                starve_cnt <= '0;
            else if (grant_mem && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered responses: one-cycle valid pulse, payload held until the next response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_rsp_valid  <= 1'b0;
            if_rsp_instr  <= '0;
            if_rsp_err    <= 1'b0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_rdata <= '0;
            mem_rsp_err   <= 1'b0;
        end else begin
            if_rsp_valid  <= 1'b0;
            mem_rsp_valid <= 1'b0;
            if (rsp_done) begin
                if (owner == OWN_IF) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_err   <= 1'b0;
                    if_rsp_instr <= lat_addr[2] ? bus_rsp_rdata[2*INST_W-1:INST_W]
                                                : bus_rsp_rdata[INST_W-1:0];
                end else begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_err   <= 1'b0;
                    mem_rsp_rdata <= lat_wr ? '0 : bus_rsp_rdata;
                end
            end else if (state == ST_ERR) begin
                if (owner == OWN_IF) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_err   <= 1'b1;
                    if_rsp_instr <= '0;
                end else begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_err   <= 1'b1;
                    mem_rsp_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit memory port between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences one outstanding bus transaction at a time and generates the byte write mask.
- Routes the response back to the owning requester and reports misaligned accesses.
- Sits between the pipeline top and the memory model or bus, replacing direct per-stage memory calls.

Parameters:
- ADDR_W, 64, address width (PC/MEM bus).
- DATA_W, 64, memory data width.
- INST_W, 32, instruction width.
- STARVE_LIMIT, 4, number of consecutive MEM grants, taken while IF is waiting, after which IF gets priority.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDR_W  fetch address (PC).
- if_rsp_valid  out  1  one-cycle fetch response pulse.
- if_rsp_instr  out  INST_W  fetched instruction.
- if_rsp_err  out  1  fetch misaligned (addr[1:0]!=0).
- mem_req_valid  in  1  data request.
- mem_req_ready  out  1  data request accepted.
- mem_req_wr  in  1  1=store, 0=load.
- mem_req_size  in  2  B=0, H=1, W=2, D=3.
- mem_req_addr  in  ADDR_W  data address.
- mem_req_wdata  in  DATA_W  store data, already lane-aligned.
- mem_rsp_valid  out  1  one-cycle data response pulse (loads and stores).
- mem_rsp_rdata  out  DATA_W  raw 64-bit load word; 0 for stores.
- mem_rsp_err  out  1  data access misaligned.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts request.
- bus_req_wr  out  1  write.
- bus_req_addr  out  ADDR_W  address.
- bus_req_wdata  out  DATA_W  write data.
- bus_req_wmask  out  8  byte enables.
- bus_rsp_valid  in  1  bus response or write ack.
- bus_rsp_rdata  in  DATA_W  read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; owner=NONE; starve_cnt=0.
  - All outputs are 0; any in-flight transaction is dropped with no response pulse.
- FSM states:
  - IDLE
    - Grant is combinational. The *_req_ready of the winner is high only in IDLE.
    - On handshake, latch addr, wr, wdata and wmask and record the owner.
    - Aligned request → REQ next cycle. Misaligned request → ERR next cycle.
  - REQ
    - bus_req_valid=1; request fields are held stable.
    - bus_req_ready=1 → WAIT; otherwise stay in REQ.
  - WAIT
    - bus_req_valid=0.
    - bus_rsp_valid=1 → capture bus_rsp_rdata, go to IDLE, and pulse the owner's rsp_valid the next cycle.
  - ERR
    - No bus activity.
    - Pulse the owner's rsp_valid with rsp_err=1 for one cycle, then go to IDLE.
- Response outputs are registered.
  - *_rsp_valid is high for exactly one cycle.
  - rsp data is held until the next response.
- Minimum latency from request accept to response pulse:
  - 3 cycles with a zero-wait bus (accept c0, bus_req_valid c1, bus_rsp_valid c2, rsp_valid c3).
  - A new request can be accepted in the same cycle the response pulse is high (state is IDLE).
- Arbitration when both valid in IDLE:
  - MEM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments, saturating, on each MEM grant while if_req_valid=1.
  - starve_cnt clears on an IF grant, or when if_req_valid=0 in IDLE.
- wmask:
  - D=8'hFF.
  - W=8'h0F<<addr[2:0] (addr[2]∈{0,4}).
  - H=8'h03<<addr[2:0].
  - B=8'h01<<addr[2:0].
  - Loads carry the same mask; the bus ignores it.
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0; D with addr[2:0]≠0; IF with addr[1:0]≠0.
- Fetch data: if_rsp_instr = addr[2] ? rdata[63:32] : rdata[31:0], using the latched address.
- Requesters must hold request fields stable while valid=1 && ready=0.
- bus_rsp_valid outside WAIT is ignored.

Decomposition:
- Shared defines header holds:
  - SIZE_B/H/W/D encodings.
  - ADDR/DATA/INST bus widths.
  - FSM state encodings (IDLE=0, REQ=1, WAIT=2, ERR=3).
  - Owner encoding (NONE, IF, MEM).
- One combinational sub-module, mem_wmask_gen: (size, addr[2:0]) → wmask, misalign. It is reused by the store path elsewhere.
- Arbiter FSM, starvation counter and response registers stay in mem_port_arbiter.

Test Plan:
- IF-only fetch: addr=0x80000004, bus returns rdata=0x00100093_00000013 after 0 wait → if_rsp_valid at c3, if_rsp_instr=0x00100093.
- Simultaneous IF+MEM load of D at 0x80001000 → MEM granted first and bus sees wmask=0xFF; IF accepted in the cycle mem_rsp_valid pulses.
- Store H to addr 0x...06, wdata=0xBEEF<<48 → bus_req_wr=1, wmask=0xC0, mem_rsp_valid=1 with rdata=0, err=0.
- Misaligned W load at 0x...02 → no bus_req_valid, mem_rsp_valid and mem_rsp_err=1 two cycles after accept.
- Starvation: MEM and IF valid continuously, STARVE_LIMIT=4 → grants M,M,M,M,I; counter then clears.
- Bus backpressure with bus_req_ready low for 5 cycles, then reset=0 during WAIT → fields held stable in REQ; after reset, all outputs 0, state IDLE, no rsp pulse, and a fresh request is served normally.
